// File: rtl/romctrl_mc_if.sv
// Request-side bus of the flash ROM line controller: per-channel strobes and line
// addresses in, a shared line-data bus and per-channel ack/timeout pulses out.
interface romctrl_mc_if #(
    parameter int unsigned NCH        = 2,
    parameter int unsigned REQ_AW     = 24,
    parameter int unsigned LINE_BYTES = 16
);
    logic [NCH-1:0]          req_stb;
    logic [NCH*REQ_AW-1:0]   req_addr;
    logic [LINE_BYTES*8-1:0] req_dout;
    logic [NCH-1:0]          req_ack;
    logic [NCH-1:0]          req_timeout;

    modport master (
        output req_stb, req_addr,
        input  req_dout, req_ack, req_timeout
    );

    modport slave (
        input  req_stb, req_addr,
        output req_dout, req_ack, req_timeout
    );
endinterface

// File: rtl/romctrl_mc.sv
// Multi-channel NOR flash line fetcher with fixed-priority arbitration (channel 0 highest).
// Optional single-line hit buffer on req_dout enabled by defining ROMCTRL_LINEBUF_EN.
module romctrl_mc #(
    parameter int unsigned NCH        = 2,
    parameter int unsigned REQ_AW     = 24,
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned FL_DW      = 8,
    parameter int unsigned FL_AW      = 23,
    parameter int unsigned RD_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst,
    romctrl_mc_if.slave      bus,
    output logic             fl_ce_n,
    output logic             fl_oe_n,
    output logic             fl_we_n,
    output logic             fl_wp_n,
    output logic             fl_rst_n,
    output logic [FL_AW-1:0] fl_a,
    input  logic [FL_DW-1:0] fl_d
);
    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam int unsigned BEATS  = LINE_W / FL_DW;
    localparam int unsigned LA_W   = $clog2(BEATS);
    localparam int unsigned LN_W   = FL_AW - LA_W;
    localparam int unsigned GW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned TW     = $clog2(RD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, READ, ACK, TMO} state_t;

    state_t            state, state_nxt;
    logic [GW-1:0]     grant, grant_nxt;
    logic [LN_W-1:0]   line;
    logic [LA_W-1:0]   beat;
    logic [TW-1:0]     timer;
    logic              req_any;
    logic [GW-1:0]     sel;
    logic [REQ_AW-1:0] sel_addr;
    logic [LN_W-1:0]   sel_line;
    logic              in_range;
    logic              hit;
    logic              line_ld;
    logic              beat_end;
    logic [NCH-1:0]    ack_nxt, tmo_nxt;

    assign fl_ce_n  = 1'b0;
    assign fl_oe_n  = 1'b0;
    assign fl_we_n  = 1'b1;
    assign fl_wp_n  = 1'b1;
    assign fl_rst_n = 1'b1;
    assign fl_a     = {line, beat};

    // Fixed priority: scanning downwards leaves the lowest requesting index selected
    always_comb begin
        req_any  = 1'b0;
        sel      = '0;
        sel_addr = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (bus.req_stb[i]) begin
                req_any  = 1'b1;
                sel      = GW'(i);
                sel_addr = bus.req_addr[i*REQ_AW +: REQ_AW];
            end
        end
    end

    assign sel_line = LN_W'(sel_addr);
    assign in_range = ((sel_addr >> LN_W) == '0);
    assign beat_end = (timer == '0);

`ifdef ROMCTRL_LINEBUF_EN
    logic [LN_W-1:0] tag;
    logic            tag_valid;

    // Tag tracks the line currently on req_dout; any refill invalidates it until ack
    always_ff @(posedge clk) begin
        if (rst) begin
            tag       <= '0;
            tag_valid <= 1'b0;
        end else if (line_ld) begin
            tag_valid <= 1'b0;
        end else if (state == ACK) begin
            tag       <= line;
            tag_valid <= 1'b1;
        end
    end

    assign hit = tag_valid && (tag == sel_line);
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        line_ld   = 1'b0;
        ack_nxt   = '0;
        tmo_nxt   = '0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    grant_nxt = sel;
                    if (!in_range) begin
                        state_nxt = TMO;
                    end else if (hit) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt = READ;
                        line_ld   = 1'b1;
                    end
                end
            end
            READ: begin
                if (beat_end && (beat == LA_W'(BEATS - 1))) state_nxt = ACK;
            end
            ACK:     state_nxt = IDLE;
            TMO:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Pulses are registered so they are high exactly while in ACK/TMO
        if (state_nxt == ACK) ack_nxt = NCH'(1) << grant_nxt;
        if (state_nxt == TMO) tmo_nxt = NCH'(1) << grant_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant           <= '0;
            line            <= '0;
            beat            <= '0;
            timer           <= '0;
            bus.req_ack     <= '0;
            bus.req_timeout <= '0;
        end else begin
            grant           <= grant_nxt;
            bus.req_ack     <= ack_nxt;
            bus.req_timeout <= tmo_nxt;
            if (line_ld) begin
                line  <= sel_line;
                beat  <= '0;
                timer <= TW'(RD_CYCLES - 1);
            end else if (state == READ) begin
                if (beat_end) begin
                    timer <= TW'(RD_CYCLES - 1);
                    beat  <= beat + LA_W'(1);
                end else begin
                    timer <= timer - TW'(1);
                end
            end else if (state == ACK) begin
                beat <= '0;
            end
        end
    end

    // Line data is not reset: it survives an aborted fill with whatever beats landed
    always_ff @(posedge clk) begin
        if (!rst && (state == READ) && beat_end) begin
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (beat == LA_W'(k)) bus.req_dout[LINE_W-1-k*FL_DW -: FL_DW] <= fl_d;
            end
        end
    end
endmodule

// File: tb/tb_romctrl_mc.sv
// Directed bench for romctrl_mc: a default 8-bit instance and a 16-bit, 3-cycle instance.
module tb_romctrl_mc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    romctrl_mc_if #(.NCH(2), .REQ_AW(24), .LINE_BYTES(16)) bus0();
    romctrl_mc_if #(.NCH(2), .REQ_AW(24), .LINE_BYTES(16)) bus1();

    logic        fl0_ce_n, fl0_oe_n, fl0_we_n, fl0_wp_n, fl0_rst_n;
    logic        fl1_ce_n, fl1_oe_n, fl1_we_n, fl1_wp_n, fl1_rst_n;
    logic [22:0] fl0_a, fl1_a;
    logic [7:0]  fl0_d;
    logic [15:0] fl1_d;

    assign fl0_d = fl0_a[7:0];
    assign fl1_d = {fl1_a[7:0], ~fl1_a[7:0]};

    romctrl_mc #(.NCH(2), .REQ_AW(24), .LINE_BYTES(16), .FL_DW(8), .FL_AW(23), .RD_CYCLES(10)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .fl_ce_n(fl0_ce_n), .fl_oe_n(fl0_oe_n), .fl_we_n(fl0_we_n), .fl_wp_n(fl0_wp_n),
        .fl_rst_n(fl0_rst_n), .fl_a(fl0_a), .fl_d(fl0_d)
    );

    romctrl_mc #(.NCH(2), .REQ_AW(24), .LINE_BYTES(16), .FL_DW(16), .FL_AW(23), .RD_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .fl_ce_n(fl1_ce_n), .fl_oe_n(fl1_oe_n), .fl_we_n(fl1_we_n), .fl_wp_n(fl1_wp_n),
        .fl_rst_n(fl1_rst_n), .fl_a(fl1_a), .fl_d(fl1_d)
    );

    int checks   = 0;
    int failures = 0;
    int fl_chg   = 0;
    logic [22:0] fl_prev = '0;

    // Counts every change of the default instance's flash address
    always @(negedge clk) begin
        if (fl0_a != fl_prev) fl_chg++;
        fl_prev = fl0_a;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycles from the request cycle to the first ack/timeout on bus0; -1 if none in budget
    task automatic wait_any(output int n, output logic [1:0] ack, output logic [1:0] tmo,
                            output logic [22:0] a_first, output logic [22:0] a_last);
        logic done;
        n = -1; ack = '0; tmo = '0; a_first = '0; a_last = '0; done = 1'b0;
        for (int i = 1; i <= 400 && !done; i++) begin
            @(posedge clk);
            @(negedge clk);
            if ((bus0.req_ack | bus0.req_timeout) != 2'b00) begin
                n = i; ack = bus0.req_ack; tmo = bus0.req_timeout; done = 1'b1;
            end else begin
                if (i == 1) a_first = fl0_a;
                a_last = fl0_a;
            end
        end
    endtask

    int          n;
    int          base;
    logic [1:0]  ack, tmo, seen;
    logic [22:0] af, al;
    logic        done1;

    initial begin
        rst = 1'b1;
        bus0.req_stb = '0; bus0.req_addr = '0;
        bus1.req_stb = '0; bus1.req_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ack", 128'(bus0.req_ack), 128'h0);
        check("rst_tmo", 128'(bus0.req_timeout), 128'h0);
        check("rst_pins", 128'({fl0_ce_n, fl0_oe_n, fl0_we_n, fl0_wp_n, fl0_rst_n}), 128'h07);
        check("rst_ack1", 128'(bus1.req_ack | bus1.req_timeout), 128'h0);

        // ch1 reads line 0x10
        @(negedge clk);
        bus0.req_addr[24 +: 24] = 24'h000010;
        bus0.req_stb = 2'b10;
        wait_any(n, ack, tmo, af, al);
        bus0.req_stb = 2'b00;
        check("t1_lat", 128'(n), 128'd161);
        check("t1_ack", 128'(ack), 128'h2);
        check("t1_tmo", 128'(tmo), 128'h0);
        check("t1_dout", bus0.req_dout, 128'h000102030405060708090A0B0C0D0E0F);
        check("t1_a_first", 128'(af), 128'h000100);
        check("t1_a_last", 128'(al), 128'h00010F);

        // 16-bit beats, 3 cycles each, on the second instance
        @(negedge clk);
        bus1.req_addr[0 +: 24] = 24'h000012;
        bus1.req_stb = 2'b01;
        n = -1; ack = '0; done1 = 1'b0;
        for (int i = 1; i <= 100 && !done1; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus1.req_ack != 2'b00) begin
                n = i; ack = bus1.req_ack; done1 = 1'b1;
            end
        end
        bus1.req_stb = 2'b00;
        check("t5_lat", 128'(n), 128'd25);
        check("t5_ack", 128'(ack), 128'h1);
        check("t5_dout", bus1.req_dout, 128'h906F916E926D936C946B956A96699768);

        // Simultaneous strobes: ch0 first, ch1 granted the cycle after ack[0]
        @(negedge clk);
        bus0.req_addr[0 +: 24]  = 24'h000021;
        bus0.req_addr[24 +: 24] = 24'h000032;
        bus0.req_stb = 2'b11;
        wait_any(n, ack, tmo, af, al);
        bus0.req_stb[0] = 1'b0;
        check("t2_lat0", 128'(n), 128'd161);
        check("t2_ack0", 128'(ack), 128'h1);
        check("t2_dout0", bus0.req_dout, 128'h101112131415161718191A1B1C1D1E1F);
        wait_any(n, ack, tmo, af, al);
        bus0.req_stb = 2'b00;
        check("t2_lat1", 128'(n), 128'd162);
        check("t2_ack1", 128'(ack), 128'h2);
        check("t2_dout1", bus0.req_dout, 128'h202122232425262728292A2B2C2D2E2F);

        // Out-of-range address times out without touching the flash
        @(negedge clk);
        bus0.req_addr[0 +: 24] = 24'h080000;
        bus0.req_stb = 2'b01;
        wait_any(n, ack, tmo, af, al);
        bus0.req_stb = 2'b00;
        check("t3_lat", 128'(n), 128'd1);
        check("t3_tmo", 128'(tmo), 128'h1);
        check("t3_ack", 128'(ack), 128'h0);
        check("t3_fl_a", 128'(fl0_a), 128'h000320);

        // Reset at READ cycle 50 with ch1 strobe held
        @(negedge clk);
        bus0.req_addr[24 +: 24] = 24'h000044;
        bus0.req_stb = 2'b10;
        seen = '0;
        repeat (50) begin
            @(posedge clk);
            @(negedge clk);
            seen = seen | bus0.req_ack | bus0.req_timeout;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = seen | bus0.req_ack | bus0.req_timeout;
        check("t4_no_ack", 128'(seen), 128'h0);
        wait_any(n, ack, tmo, af, al);
        bus0.req_stb = 2'b00;
        check("t4_lat", 128'(n), 128'd161);
        check("t4_ack", 128'(ack), 128'h2);
        check("t4_dout", bus0.req_dout, 128'h404142434445464748494A4B4C4D4E4F);

        // Line 0x5 twice, then line 0x6
        @(negedge clk);
        bus0.req_addr[0 +: 24] = 24'h000005;
        bus0.req_stb = 2'b01;
        wait_any(n, ack, tmo, af, al);
        bus0.req_stb = 2'b00;
        check("t6_lat_a", 128'(n), 128'd161);
        check("t6_dout_a", bus0.req_dout, 128'h505152535455565758595A5B5C5D5E5F);
        repeat (2) @(negedge clk);
        base = fl_chg;
        bus0.req_stb = 2'b01;
        wait_any(n, ack, tmo, af, al);
        bus0.req_stb = 2'b00;
        repeat (3) @(negedge clk);
`ifdef ROMCTRL_LINEBUF_EN
        check("t6_lat_hit", 128'(n), 128'd1);
        check("t6_fl_chg", 128'(fl_chg - base), 128'd0);
`else
        check("t6_lat_hit", 128'(n), 128'd161);
        check("t6_fl_chg", 128'(fl_chg - base), 128'd16);
`endif
        check("t6_ack_hit", 128'(ack), 128'h1);
        check("t6_dout_hit", bus0.req_dout, 128'h505152535455565758595A5B5C5D5E5F);
        check("t6_fl_a_hit", 128'(fl0_a), 128'h000050);
        bus0.req_addr[0 +: 24] = 24'h000006;
        bus0.req_stb = 2'b01;
        wait_any(n, ack, tmo, af, al);
        bus0.req_stb = 2'b00;
        check("t6_lat_c", 128'(n), 128'd161);
        check("t6_dout_c", bus0.req_dout, 128'h606162636465666768696A6B6C6D6E6F);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
